// File: rtl/rsa_encrypt_controller.sv
// -----------------------------------------------------------------------------
// rsa_encrypt_controller
//
// Sequencing FSM placed directly upstream of the RSA modular-exponentiation
// datapath (n = 3233, e = 17). It accepts one plaintext byte over a
// valid/ready handshake. It then steps the datapath through initialize and
// repeated multiply/modulo rounds until the datapath reports completion. The
// controller captures the 16-bit ciphertext and offers it downstream over a
// second valid/ready handshake. An iteration watchdog aborts the transaction
// if completion is never reported.
//
// Ports
//   clk, rst_n              : clock (rising edge), async active-low reset
//   in_valid/in_ready       : plaintext handshake; in_ready high only in IDLE
//   in_data[7:0]            : plaintext byte
//   data[7:0]               : held plaintext byte presented to the datapath
//   initialize, en_multiply,
//   en_modulo, done         : datapath strobes; one-hot, Moore decodes of state
//   is_multiplication_done  : datapath completion flag (registered in datapath)
//   output_data[15:0]       : datapath result, valid the cycle after done
//   out_valid/out_ready     : ciphertext handshake
//   out_data[15:0]          : ciphertext, held stable while out_valid is high
//   busy                    : high in every state except IDLE
//   err                     : one-cycle pulse on watchdog abort
//
// MAX_ITERS must be strictly below 2**CNT_W so that the saturating iteration
// counter can represent the abort threshold.
// -----------------------------------------------------------------------------
module rsa_encrypt_controller #(
  parameter int unsigned MAX_ITERS = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [7:0]  data,
  output logic        initialize,
  output logic        en_multiply,
  output logic        en_modulo,
  output logic        done,
  input  logic        is_multiplication_done,
  input  logic [15:0] output_data,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_MULT,
    S_MOD,
    S_CHECK,
    S_FINISH,
    S_CAPTURE,
    S_OUT,
    S_ABORT
  } state_e;

  localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITERS);

  state_e            state_q,     state_d;
  logic [7:0]        data_q,      data_d;
  logic [CNT_W-1:0]  iter_cnt_q,  iter_cnt_d;
  logic [15:0]       out_data_q,  out_data_d;
  logic              out_valid_q, out_valid_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its next-state value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      iter_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      iter_cnt_q  <= iter_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: every signal driven here gets a hold-value default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    iter_cnt_d  = iter_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        // in_ready is asserted throughout IDLE, so in_valid alone completes
        // the handshake here.
        if (in_valid) begin
          data_d     = in_data;
          iter_cnt_d = '0;
          state_d    = S_INIT;
        end
      end
      S_INIT: state_d = S_MULT;
      S_MULT: begin
        // Saturate rather than wrap so a runaway datapath cannot skip the
        // abort threshold.
        if (iter_cnt_q != ITER_LIMIT) iter_cnt_d = iter_cnt_q + CNT_W'(1);
        state_d = S_MOD;
      end
      S_MOD: state_d = S_CHECK;
      S_CHECK: begin
        // Completion wins over the watchdog when both happen on the last round.
        if (is_multiplication_done)        state_d = S_FINISH;
        else if (iter_cnt_q == ITER_LIMIT) state_d = S_ABORT;
        else                               state_d = S_MULT;
      end
      S_FINISH: state_d = S_CAPTURE;
      S_CAPTURE: begin
        // The datapath latches its result on the done edge, so output_data
        // is valid in this cycle.
        out_data_d  = output_data;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore decodes: strobes and handshake qualifiers depend on state only.
  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign initialize  = (state_q == S_INIT);
  assign en_multiply = (state_q == S_MULT);
  assign en_modulo   = (state_q == S_MOD);
  assign done        = (state_q == S_FINISH);
  assign err         = (state_q == S_ABORT);
  assign data        = data_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_rsa_encrypt_controller.sv
// -----------------------------------------------------------------------------
// tb_rsa_encrypt_controller
//
// Directed bench for rsa_encrypt_controller. A behavioural datapath stub
// computes m^17 mod 3233 by repeated multiply/modulo, driven only by the
// controller strobes. Expected ciphertexts are hand-computed:
// 65 -> 2790, 2 -> 1752, 0 -> 0, 1 -> 1.
// Timing convention: E0 is the accepting edge, and cycle k is the interval
// between edges E(k-1) and Ek.
// -----------------------------------------------------------------------------
module tb_rsa_encrypt_controller;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  data;
  logic        initialize, en_multiply, en_modulo, done;
  logic        is_multiplication_done;
  logic [15:0] output_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  rsa_encrypt_controller #(.MAX_ITERS(16), .CNT_W(5)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .in_valid               (in_valid),
    .in_data                (in_data),
    .in_ready               (in_ready),
    .data                   (data),
    .initialize             (initialize),
    .en_multiply            (en_multiply),
    .en_modulo              (en_modulo),
    .done                   (done),
    .is_multiplication_done (is_multiplication_done),
    .output_data            (output_data),
    .out_valid              (out_valid),
    .out_data               (out_data),
    .out_ready              (out_ready),
    .busy                   (busy),
    .err                    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Datapath stub (no reset, like the real datapath).
  // ---------------------------------------------------------------------------
  logic [31:0] acc    = '0;
  int          mcnt   = 0;
  logic [15:0] dp_out = '0;
  logic        dp_force_not_done = 1'b0;

  always @(posedge clk) begin
    if (initialize) begin
      acc  <= {24'd0, data};
      mcnt <= 0;
    end else if (en_multiply) begin
      acc  <= acc * {24'd0, data};
      mcnt <= mcnt + 1;
    end else if (en_modulo) begin
      acc  <= acc % 32'd3233;
    end
    if (done) dp_out <= acc[15:0];
  end

  assign is_multiplication_done = !dp_force_not_done && (mcnt == 16);
  assign output_data            = dp_out;

  // ---------------------------------------------------------------------------
  // Transaction driver: presents a byte, then observes the controller cycle by
  // cycle until out_valid or err. It returns at the negedge where that was seen.
  // ---------------------------------------------------------------------------
  typedef struct {
    int          wait_cyc;
    int          lat;
    int          done_cyc;
    int          err_cyc;
    int          mults;
    int          errs;
    int          busy_viol;
    int          strobe_viol;
    int          data_viol;
    logic        got_out;
    logic        timed_out;
    logic [15:0] result;
  } txn_t;

  task automatic run_txn(input logic [7:0] b, input bit hold, output txn_t r);
    r = '{default: 0};
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && r.wait_cyc < 200) begin
      @(negedge clk);
      r.wait_cyc++;
    end
    if (!in_ready) begin
      r.timed_out = 1'b1;
      in_valid    = 1'b0;
      return;
    end
    @(posedge clk);  // E0
    r.timed_out = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (en_multiply) r.mults++;
      if (done) r.done_cyc = k;
      if ((int'(initialize) + int'(en_multiply) + int'(en_modulo) + int'(done)) > 1)
        r.strobe_viol++;
      if (in_ready || !busy) r.busy_viol++;
      if (k <= 50 && data !== b) r.data_viol++;
      if (hold) in_data = b + 8'(k);
      else      in_valid = 1'b0;
      if (err) begin
        r.errs++;
        r.err_cyc   = k;
        r.timed_out = 1'b0;
        break;
      end
      if (out_valid) begin
        r.got_out   = 1'b1;
        r.lat       = k - 1;
        r.result    = out_data;
        r.timed_out = 1'b0;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_checks++; if ({initialize, en_multiply, en_modulo, done} !== 4'b0000) begin n_fail++; $display("FAIL reset_strobes: got %b, expected 0000", {initialize, en_multiply, en_modulo, done}); end
    n_checks++; if ({out_valid, err} !== 2'b00) begin n_fail++; $display("FAIL reset_valid_err: got %b, expected 00", {out_valid, err}); end
    n_checks++; if (data !== 8'd0 || out_data !== 16'd0) begin n_fail++; $display("FAIL reset_data: got data=%0d out_data=%0d, expected 0/0", data, out_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    txn_t r;
    out_ready = 1'b1;
    run_txn(8'd65, 1'b0, r);
    n_checks++; if (r.timed_out !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b, expected 0", r.timed_out); end
    n_checks++; if (r.result !== 16'd2790) begin n_fail++; $display("FAIL basic_result: got %0d, expected 2790", r.result); end
    n_checks++; if (r.lat !== 51) begin n_fail++; $display("FAIL basic_latency: got %0d, expected 51", r.lat); end
    n_checks++; if (r.done_cyc !== 50) begin n_fail++; $display("FAIL basic_done_cycle: got %0d, expected 50", r.done_cyc); end
    n_checks++; if (r.mults !== 16) begin n_fail++; $display("FAIL basic_mults: got %0d, expected 16", r.mults); end
    n_checks++; if (r.errs !== 0) begin n_fail++; $display("FAIL basic_err: got %0d pulses, expected 0", r.errs); end
    n_checks++; if (r.busy_viol !== 0 || r.strobe_viol !== 0) begin n_fail++; $display("FAIL basic_decode: got busy_viol=%0d strobe_viol=%0d, expected 0/0", r.busy_viol, r.strobe_viol); end
    n_checks++; if (r.data_viol !== 0) begin n_fail++; $display("FAIL basic_data_hold: got %0d bad cycles, expected 0", r.data_viol); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes [3] = '{8'd2, 8'd0, 8'd1};
    logic [15:0] exp_c [3] = '{16'd1752, 16'd0, 16'd1};
    txn_t r;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_txn(bytes[i], 1'b0, r);
      n_checks++; if (r.result !== exp_c[i] || r.got_out !== 1'b1) begin n_fail++; $display("FAIL b2b_result[%0d]: got %0d (valid %b), expected %0d", i, r.result, r.got_out, exp_c[i]); end
      n_checks++; if (r.lat !== 51) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d, expected 51", i, r.lat); end
      n_checks++; if (r.busy_viol !== 0) begin n_fail++; $display("FAIL b2b_in_ready_busy[%0d]: got %0d bad cycles, expected 0", i, r.busy_viol); end
      // Previous transaction is still in OUT when the next byte is offered.
      if (i > 0) begin
        n_checks++; if (r.wait_cyc !== 1) begin n_fail++; $display("FAIL b2b_accept_gap[%0d]: got %0d, expected 1", i, r.wait_cyc); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_out_stall();
    txn_t r;
    out_ready = 1'b0;
    run_txn(8'd65, 1'b0, r);
    n_checks++; if (r.result !== 16'd2790) begin n_fail++; $display("FAIL stall_result: got %0d, expected 2790", r.result); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (out_valid !== 1'b1 || out_data !== 16'd2790 || in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b data=%0d in_ready=%b, expected 1/2790/0", i, out_valid, out_data, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got in_ready=%b valid=%b, expected 1/0", in_ready, out_valid); end
  endtask

  task automatic test_watchdog();
    txn_t r;
    dp_force_not_done = 1'b1;
    out_ready = 1'b1;
    run_txn(8'd65, 1'b0, r);
    n_checks++; if (r.got_out !== 1'b0 || r.timed_out !== 1'b0) begin n_fail++; $display("FAIL wd_no_output: got valid=%b timeout=%b, expected 0/0", r.got_out, r.timed_out); end
    n_checks++; if (r.mults !== 16) begin n_fail++; $display("FAIL wd_mults: got %0d, expected 16", r.mults); end
    n_checks++; if (r.errs !== 1 || r.err_cyc !== 50) begin n_fail++; $display("FAIL wd_err: got %0d pulses at cycle %0d, expected 1 at 50", r.errs, r.err_cyc); end
    @(negedge clk);
    n_checks++; if (err !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL wd_idle: got err=%b in_ready=%b busy=%b valid=%b, expected 0/1/0/0", err, in_ready, busy, out_valid); end
    dp_force_not_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    txn_t r;
    int   w = 0;
    out_ready = 1'b1;
    in_data   = 8'd65;
    in_valid  = 1'b1;
    while (!in_ready && w < 200) begin @(negedge clk); w++; end
    @(posedge clk);                 // E0
    @(negedge clk); in_valid = 1'b0; // cycle 1
    repeat (23) @(negedge clk);     // cycle 24 = 8th MOD
    n_checks++; if (en_modulo !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_mod: got en_modulo=%b, expected 1", en_modulo); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got in_ready=%b busy=%b, expected 1/0", in_ready, busy); end
    n_checks++; if ({initialize, en_multiply, en_modulo, done, out_valid, err} !== 6'd0) begin n_fail++; $display("FAIL rstmid_outputs: got %b, expected 000000", {initialize, en_multiply, en_modulo, done, out_valid, err}); end
    n_checks++; if (data !== 8'd0 || out_data !== 16'd0) begin n_fail++; $display("FAIL rstmid_data: got data=%0d out_data=%0d, expected 0/0", data, out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(8'd65, 1'b0, r);
    n_checks++; if (r.result !== 16'd2790 || r.lat !== 51) begin n_fail++; $display("FAIL rstmid_recover: got %0d latency %0d, expected 2790 latency 51", r.result, r.lat); end
  endtask

  task automatic test_hold_valid();
    txn_t r1, r2;
    out_ready = 1'b1;
    run_txn(8'd2, 1'b1, r1);  // in_valid stays high, in_data changes every cycle
    n_checks++; if (r1.result !== 16'd1752) begin n_fail++; $display("FAIL hold_first_byte: got %0d, expected 1752", r1.result); end
    n_checks++; if (r1.data_viol !== 0) begin n_fail++; $display("FAIL hold_data_stable: got %0d bad cycles, expected 0", r1.data_viol); end
    run_txn(8'd1, 1'b0, r2);
    n_checks++; if (r2.wait_cyc !== 1) begin n_fail++; $display("FAIL hold_next_accept: got gap %0d, expected 1", r2.wait_cyc); end
    n_checks++; if (r2.result !== 16'd1) begin n_fail++; $display("FAIL hold_second_byte: got %0d, expected 1", r2.result); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_out_stall();
    test_watchdog();
    test_reset_mid();
    test_hold_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
